// File: rtl/cpld_bank_wrsync.sv
// Clocked front end for the 512K RAM expansion bank register: bus synchronisers, write glitch filter, INTACK rejection.
// Define BANK_READBACK_EN to add the data_out/data_oe I/O readback path.
module cpld_bank_wrsync #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iorq_b,
    input  logic       m1_b,
    input  logic       wr_b,
    input  logic       rd_b,
    input  logic       adr15,
    input  logic [7:0] data,
    output logic [5:0] ramblock,
    output logic       blk_update,
    output logic       busy
`ifdef BANK_READBACK_EN
    ,
    output logic [7:0] data_out,
    output logic       data_oe
`endif
);

    typedef enum logic [1:0] {IDLE, ARMED, HOLD} state_t;

    localparam int          BW      = 13;
    localparam logic [BW-1:0] BUS_IDLE = {8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam logic [2:0]  FILT    = 3'(FILTER_CYCLES);

    logic [BW-1:0] bus_raw;
    logic [BW-1:0] sync_q [SYNC_STAGES];
    logic [BW-1:0] bus_s;

    assign bus_raw = {data, adr15, rd_b, wr_b, m1_b, iorq_b};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= BUS_IDLE;
            end
        end else begin
            sync_q[0] <= bus_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign bus_s = sync_q[SYNC_STAGES-1];

    logic       iorq_s, m1_s, wr_s, rd_s, adr15_s;
    logic [7:0] data_s;
    logic       qual_s;

    assign iorq_s  = bus_s[0];
    assign m1_s    = bus_s[1];
    assign wr_s    = bus_s[2];
    assign rd_s    = bus_s[3];
    assign adr15_s = bus_s[4];
    assign data_s  = bus_s[12:5];
    assign qual_s  = !iorq_s & m1_s & !wr_s & !adr15_s & data_s[7] & data_s[6];

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d, cnt_inc;
    logic [5:0] cap_q, cap_d;
    logic [5:0] ramblock_q, ramblock_d;
    logic       blk_update_q, blk_update_d;

    assign cnt_inc = (cnt_q == 3'd7) ? 3'd7 : cnt_q + 3'd1;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cap_d        = cap_q;
        ramblock_d   = ramblock_q;
        blk_update_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (qual_s) begin
                    cap_d = data_s[5:0];
                    if (FILTER_CYCLES == 1) begin
                        ramblock_d   = data_s[5:0];
                        blk_update_d = 1'b1;
                        state_d      = HOLD;
                        cnt_d        = 3'd0;
                    end else begin
                        state_d = ARMED;
                        cnt_d   = 3'd1;
                    end
                end
            end
            ARMED: begin
                if (!qual_s) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end else if (data_s[5:0] != cap_q) begin
                    cap_d = data_s[5:0];
                    cnt_d = 3'd1;
                end else if (cnt_inc == FILT) begin
                    ramblock_d   = cap_q;
                    blk_update_d = 1'b1;
                    state_d      = HOLD;
                    cnt_d        = 3'd0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HOLD: begin
                // One update per IORQ assertion: wait for the strobe to drop.
                if (iorq_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            cap_q        <= 6'd0;
            ramblock_q   <= 6'd0;
            blk_update_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cap_q        <= cap_d;
            ramblock_q   <= ramblock_d;
            blk_update_q <= blk_update_d;
        end
    end

    assign ramblock   = ramblock_q;
    assign blk_update = blk_update_q;
    assign busy       = (state_q == ARMED) || (state_q == HOLD);

`ifdef BANK_READBACK_EN
    logic data_oe_q, data_oe_d;

    // A pending or held write owns the port, so readback is suppressed outside IDLE.
    assign data_oe_d = (state_q == IDLE) && !qual_s && !iorq_s && m1_s && !rd_s && !adr15_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_oe_q <= 1'b0;
        end else begin
            data_oe_q <= data_oe_d;
        end
    end

    assign data_out = {2'b11, ramblock_q};
    assign data_oe  = data_oe_q;
`else
    logic unused_rd;
    assign unused_rd = rd_s;
`endif

endmodule

// File: tb/tb_cpld_bank_wrsync.sv
// Self-checking bench for cpld_bank_wrsync: directed test-plan steps followed by randomized bus traffic
// compared each clock against a run-length reference model of the write filter.
`timescale 1ns/1ps
module tb_cpld_bank_wrsync;

    localparam int S = 2;
    localparam int F = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       iorq_b, m1_b, wr_b, rd_b, adr15;
    logic [7:0] data;
    logic [5:0] ramblock;
    logic       blk_update;
    logic       busy;
`ifdef BANK_READBACK_EN
    logic [7:0] data_out;
    logic       data_oe;
`endif

    cpld_bank_wrsync #(.SYNC_STAGES(S), .FILTER_CYCLES(F)) dut (
        .clk        (clk),
        .reset      (reset),
        .iorq_b     (iorq_b),
        .m1_b       (m1_b),
        .wr_b       (wr_b),
        .rd_b       (rd_b),
        .adr15      (adr15),
        .data       (data),
        .ramblock   (ramblock),
        .blk_update (blk_update),
        .busy       (busy)
`ifdef BANK_READBACK_EN
        ,
        .data_out   (data_out),
        .data_oe    (data_oe)
`endif
    );

    always #125 clk = ~clk;

    typedef struct packed {
        logic       iorq;
        logic       m1;
        logic       wr;
        logic       rd;
        logic       a15;
        logic [7:0] d;
    } bus_t;

    localparam bus_t IDLE_BUS = '{iorq: 1'b1, m1: 1'b1, wr: 1'b1, rd: 1'b1, a15: 1'b0, d: 8'h00};

    int tests = 0;
    int fails = 0;
    int pulses = 0;

    // Reference model: the synchronisers are a fixed-length delay queue, the filter is
    // "FILTER_CYCLES consecutive qualified cycles carrying the same data, once per IORQ".
    bus_t       m_pipe[$];
    bit         m_hold;
    int         m_run;
    logic [5:0] m_prev;
    logic [5:0] m_ramblock;
    logic       m_update;
    logic       m_busy;
    logic       m_oe;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bus_t s, raw;
        bit   wq, rq;
        raw = '{iorq: iorq_b, m1: m1_b, wr: wr_b, rd: rd_b, a15: adr15, d: data};
        if (reset) begin
            m_pipe.delete();
            for (int i = 0; i < S; i++) m_pipe.push_back(IDLE_BUS);
            m_hold     = 0;
            m_run      = 0;
            m_prev     = '0;
            m_ramblock = '0;
            m_update   = 1'b0;
            m_oe       = 1'b0;
        end else begin
            s = m_pipe.pop_front();
            m_pipe.push_back(raw);
            wq = !s.iorq && s.m1 && !s.wr && !s.a15 && (s.d[7:6] == 2'b11);
            rq = !s.iorq && s.m1 && !s.rd && !s.a15;
            m_oe     = rq && !wq && !m_hold && (m_run == 0);
            m_update = 1'b0;
            if (m_hold) begin
                if (s.iorq) m_hold = 0;
            end else if (wq) begin
                if (m_run > 0 && s.d[5:0] == m_prev) m_run++;
                else m_run = 1;
                m_prev = s.d[5:0];
                if (m_run == F) begin
                    m_ramblock = m_prev;
                    m_update   = 1'b1;
                    m_hold     = 1;
                    m_run      = 0;
                end
            end else begin
                m_run = 0;
            end
        end
        m_busy = m_hold || (m_run > 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        if (blk_update === 1'b1) pulses++;
        check("ramblock", {2'b00, ramblock}, {2'b00, m_ramblock});
        check("blk_update", {7'd0, blk_update}, {7'd0, m_update});
        check("busy", {7'd0, busy}, {7'd0, m_busy});
`ifdef BANK_READBACK_EN
        check("data_oe", {7'd0, data_oe}, {7'd0, m_oe});
        check("data_out", data_out, {2'b11, m_ramblock});
`endif
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive(input logic io, input logic m1, input logic wr, input logic rd,
                         input logic a15, input logic [7:0] d);
        iorq_b = io;
        m1_b   = m1;
        wr_b   = wr;
        rd_b   = rd;
        adr15  = a15;
        data   = d;
    endtask

    task automatic drive_write(input logic [7:0] d);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, d);
    endtask

    task automatic drive_idle();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        int kind, len, gap;
        logic [7:0] d;

        // Reset state
        drive_idle();
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
        tick();
        check("rst_ramblock", {2'b00, ramblock}, 8'h00);
        check("rst_update", {7'd0, blk_update}, 8'h00);
        check("rst_busy", {7'd0, busy}, 8'h00);

        // Write 0xC2 held 6 clocks: update lands on clock 4
        pulses = 0;
        drive_write(8'hC2);
        ticks(3);
        check("t1_before", {2'b00, ramblock}, 8'h00);
        tick();
        check("t1_ramblock", {2'b00, ramblock}, 8'h02);
        check("t1_pulse", {7'd0, blk_update}, 8'h01);
        tick();
        check("t1_pulse_end", {7'd0, blk_update}, 8'h00);
        tick();
        drive_idle();
        ticks(2);
        check("t1_busy_hold", {7'd0, busy}, 8'h01);
        tick();
        check("t1_busy_drop", {7'd0, busy}, 8'h00);
        check("t1_pulses", 8'(pulses), 8'd1);

        // Two back-to-back writes
        pulses = 0;
        drive_write(8'hC5);
        ticks(4);
        check("t2_first", {2'b00, ramblock}, 8'h05);
        drive_idle();
        ticks(4);
        drive_write(8'hFF);
        ticks(4);
        drive_idle();
        ticks(4);
        check("t2_second", {2'b00, ramblock}, 8'h3F);
        check("t2_pulses", 8'(pulses), 8'd2);

        // One-clock IORQ glitch
        pulses = 0;
        drive_write(8'hC7);
        tick();
        drive_idle();
        ticks(5);
        check("t3_pulses", 8'(pulses), 8'd0);
        check("t3_ramblock", {2'b00, ramblock}, 8'h3F);

        // Data changes mid-window
        pulses = 0;
        drive_write(8'hC1);
        tick();
        drive_write(8'hC3);
        ticks(5);
        drive_idle();
        ticks(4);
        check("t4_pulses", 8'(pulses), 8'd1);
        check("t4_ramblock", {2'b00, ramblock}, 8'h03);

        // Non-qualifying cycles: INTACK, adr15 high, bad data, read
        pulses = 0;
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hC4);
        ticks(5);
        drive_idle(); ticks(4);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC4);
        ticks(5);
        drive_idle(); ticks(4);
        drive_write(8'h84);
        ticks(5);
        drive_idle(); ticks(4);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC4);
        ticks(5);
        drive_idle(); ticks(4);
        check("t5_pulses", 8'(pulses), 8'd0);
        check("t5_ramblock", {2'b00, ramblock}, 8'h03);

        // Reset in ARMED, write still held afterwards counts as new
        drive_write(8'hC9);
        ticks(3);
        check("t6_armed", {7'd0, busy}, 8'h01);
        reset = 1'b1;
        tick();
        check("t6_rst_ramblock", {2'b00, ramblock}, 8'h00);
        check("t6_rst_busy", {7'd0, busy}, 8'h00);
        reset = 1'b0;
        ticks(3);
        check("t6_not_yet", {2'b00, ramblock}, 8'h00);
        tick();
        check("t6_rewrite", {2'b00, ramblock}, 8'h09);

        // Reset in HOLD
        tick();
        reset = 1'b1;
        tick();
        check("t6_hold_ramblock", {2'b00, ramblock}, 8'h00);
        check("t6_hold_update", {7'd0, blk_update}, 8'h00);
        check("t6_hold_busy", {7'd0, busy}, 8'h00);
        reset = 1'b0;
        drive_idle();
        ticks(4);

`ifdef BANK_READBACK_EN
        // Readback after writing 0xCA
        drive_write(8'hCA);
        ticks(4);
        drive_idle();
        ticks(4);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        ticks(3);
        check("t7_data_oe", {7'd0, data_oe}, 8'h01);
        check("t7_data_out", data_out, 8'hCA);
        drive_idle();
        ticks(4);
`endif

        // Randomized traffic
        for (int t = 0; t < 400; t++) begin
            kind = $urandom_range(0, 8);
            len  = $urandom_range(1, 6);
            gap  = $urandom_range(0, 4);
            d    = {2'b11, 6'($urandom_range(0, 63))};
            case (kind)
                0, 1, 2: drive_write(d);
                3: begin
                    drive_write(d);
                    ticks($urandom_range(1, 3));
                    d[5:0] = 6'($urandom_range(0, 63));
                    drive_write(d);
                end
                4: drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0, d);
                5: drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, d);
                6: drive_write({2'($urandom_range(0, 2)), d[5:0]});
                7: drive(1'b0, 1'b1, 1'b1, 1'b0, 1'($urandom_range(0, 1)), d);
                default: drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                               1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            endcase
            ticks(len);
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
            drive_idle();
            adr15 = 1'($urandom_range(0, 1));
            ticks(gap);
        end
        drive_idle();
        ticks(6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
